// File: rtl/libsv_fifo_pkg.sv
// libsv_fifo_pkg: shared types and constants for the sync_fifo stream adapter.
package libsv_fifo_pkg;
  typedef enum logic [2:0] {
    ZERO = 3'b001,
    ONE  = 3'b010,
    TWO  = 3'b100
  } adapter_state_t;
  localparam int ADAPTER_DEPTH = 2;
endpackage

// File: rtl/sync_fifo_stream_adapter.sv
// sync_fifo_stream_adapter: drains a FWFT FIFO into a registered valid/ready stream via a 2-entry buffer.
// Optional statistics counters with LIBSV_SYNC_FIFO_STREAM_ADAPTER_STATS_EN.
module sync_fifo_stream_adapter
  import libsv_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  i_clock,
  input  logic                  i_aresetn,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [1:0]            o_occupancy
`ifdef LIBSV_SYNC_FIFO_STREAM_ADAPTER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] o_xfer_count,
  output logic [STAT_WIDTH-1:0] o_stall_count
`endif
);
  adapter_state_t state;
  logic [DATA_WIDTH-1:0] head, skid;
  logic pop, pop_out;
  // Popping is gated only by local state so i_ready never reaches the FIFO read enable.
  assign pop = !i_fifo_empty && (state == ZERO || state == ONE) && !i_flush && i_aresetn;
  assign pop_out = o_valid && i_ready;
  assign o_fifo_rd_en = pop;
  assign o_data = head;
  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state <= ZERO;
      head <= '0;
      skid <= '0;
      o_valid <= 1'b0;
      o_occupancy <= 2'd0;
    end else if (i_flush) begin
      state <= ZERO;
      o_valid <= 1'b0;
      o_occupancy <= 2'd0;
    end else begin
      case (state)
        ZERO: if (pop) begin
          head <= i_fifo_data;
          state <= ONE;
          o_valid <= 1'b1;
          o_occupancy <= 2'd1;
        end
        ONE: if (pop && pop_out) head <= i_fifo_data;
          else if (pop) begin
            skid <= i_fifo_data;
            state <= TWO;
            o_occupancy <= 2'(ADAPTER_DEPTH);
          end else if (pop_out) begin
            state <= ZERO;
            o_valid <= 1'b0;
            o_occupancy <= 2'd0;
          end
        TWO: if (pop_out) begin
          head <= skid;
          state <= ONE;
          o_occupancy <= 2'd1;
        end
        default: begin
          state <= ZERO;
          o_valid <= 1'b0;
          o_occupancy <= 2'd0;
        end
      endcase
    end
  end
`ifdef LIBSV_SYNC_FIFO_STREAM_ADAPTER_STATS_EN
  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_xfer_count <= '0;
      o_stall_count <= '0;
    end else if (i_flush) begin
      o_xfer_count <= '0;
      o_stall_count <= '0;
    end else begin
      if (pop_out && o_xfer_count != '1) o_xfer_count <= o_xfer_count + 1'b1;
      if (o_valid && !i_ready && o_stall_count != '1) o_stall_count <= o_stall_count + 1'b1;
    end
  end
`endif
endmodule
